vga_rx_decoder: RTL and testbench

Receive-side decoder for the 640x480 VGA output: it samples HSYNC, VSYNC and 6-bit rgb on the pixel clock and recovers the column, row and visible-area flag for each pixel. It also measures line and frame timing and reports lock status. It sits in the same pixel-clock domain as the generator and serves as a loopback checker and on-board self-test tap on the VGA adapter pins.

---
 rtl/vga_rx_decoder.sv | 144 ++++++++++++++
 tb/tb_vga_rx_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// rtl/vga_rx_decoder.sv - VGA receive-side timing recovery, pixel mapping and lock monitor
`timescale 1ns/1ps
module vga_rx_decoder #(
  parameter int H_START   = 144,
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_START   = 35,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL   = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [5:0]  rgb,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        valid,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [7:0]  err_count
);

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + H_VISIBLE);
  localparam logic [9:0]  V_LO = 10'(V_START);
  localparam logic [9:0]  V_HI = 10'(V_START + V_VISIBLE);

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

  state_t      state, state_next;
  logic        hs1, hs2, vs1, vs2;
  logic [5:0]  rgb1, rgb2;
  logic [10:0] h_off;
  logic [9:0]  line_idx;
  logic        frame_bad;
  logic        count_err;

  // h_off/line_idx describe the pixel currently in stage 2, so rgb is
  // carried through both stages to stay aligned with its position.
  logic        hs_fall, vs_fall, line_bad, frame_len_bad, visible;
  logic [11:0] len_now;

  assign hs_fall       = hs2 & ~hs1;
  assign vs_fall       = vs2 & ~vs1;
  assign len_now       = {1'b0, h_off} + 12'd1;
  assign line_bad      = (hs_fall && (len_now != 12'(H_TOTAL))) ||
                         (!hs_fall && (h_off == 11'd2046));
  assign frame_len_bad = vs_fall && (({1'b0, line_idx} + 11'd1) != 11'(V_TOTAL));
  assign visible       = (h_off >= H_LO) && (h_off < H_HI) &&
                         (line_idx >= V_LO) && (line_idx < V_HI);
  assign locked        = (state == ST_LOCKED);

  // Two-stage input register; the s2/s1 pair forms the edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {hs1, hs2, vs1, vs2} <= '0;
      rgb1 <= '0;
      rgb2 <= '0;
    end else begin
      hs1  <= HSYNC;
      hs2  <= hs1;
      vs1  <= VSYNC;
      vs2  <= vs1;
      rgb1 <= rgb;
      rgb2 <= rgb1;
    end
  end

  // Saturating horizontal offset, line index and line period measurement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_off    <= '0;
      line_idx <= '0;
      line_len <= '0;
    end else begin
      if (hs_fall)
        h_off <= '0;
      else if (h_off != 11'h7FF)
        h_off <= h_off + 11'd1;
      if (vs_fall)
        line_idx <= '0;
      else if (hs_fall && (line_idx != 10'h3FF))
        line_idx <= line_idx + 10'd1;
      if (hs_fall)
        line_len <= len_now[11] ? 11'h7FF : len_now[10:0];
    end
  end

  // Lock state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SEARCH;
    else       state <= state_next;
  end

  // Lock next-state; a coincident bad line and bad frame is one error.
  always_comb begin
    state_next = state;
    count_err  = 1'b0;
    case (state)
      ST_SEARCH: if (vs_fall) state_next = ST_CHECK;
      ST_CHECK:  if (vs_fall && !frame_bad && !line_bad && !frame_len_bad)
                   state_next = ST_LOCKED;
      ST_LOCKED: if (line_bad || frame_len_bad) begin
                   state_next = ST_SEARCH;
                   count_err  = 1'b1;
                 end
      default:   state_next = ST_SEARCH;
    endcase
  end

  // Sticky bad-line flag for the frame under test; restarts at each VSYNC fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             frame_bad <= 1'b0;
    else if (state != ST_CHECK || vs_fall) frame_bad <= 1'b0;
    else if (line_bad)                     frame_bad <= 1'b1;
  end

  // Saturating error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               err_count <= '0;
    else if (count_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

  // Registered pixel outputs; valid follows the lock state of the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      valid       <= 1'b0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      col         <= visible ? 10'(h_off - H_LO) : 10'd0;
      row         <= visible ? (line_idx - V_LO) : 10'd0;
      pix_rgb     <= visible ? rgb2 : 6'd0;
      valid       <= visible && (state_next == ST_LOCKED);
      frame_start <= vs_fall;
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb/tb_vga_rx_decoder.sv - directed bench for vga_rx_decoder on a reduced raster
`timescale 1ns/1ps
module tb_vga_rx_decoder;
  localparam int HT = 10, HS = 3, HV = 5, VT = 6, VS = 2, VV = 3, HSW = 2;

  logic        clk = 1'b0;
  logic        reset, HSYNC, VSYNC;
  logic [5:0]  rgb;
  logic [9:0]  col, row;
  logic        valid, frame_start, locked;
  logic [5:0]  pix_rgb;
  logic [10:0] line_len;
  logic [7:0]  err_count;

  int checks = 0, failures = 0;

  vga_rx_decoder #(.H_START(HS), .H_VISIBLE(HV), .H_TOTAL(HT),
                   .V_START(VS), .V_VISIBLE(VV), .V_TOTAL(VT)) dut (
    .clk(clk), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC), .rgb(rgb),
    .col(col), .row(row), .valid(valid), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .line_len(line_len),
    .err_count(err_count));

  always #5 clk = ~clk;

  // Observation of the pixel stream; per-frame stats restart on frame_start.
  int fs_cnt = 0, pix_bad = 0, seq_bad = 0, fr_valid = 0;
  bit seen = 0;
  logic [9:0] first_col = 0, first_row = 0, last_col = 0, last_row = 0;
  logic [5:0] first_rgb = 0;
  always @(negedge clk) begin
    if (frame_start) begin fs_cnt++; fr_valid = 0; seen = 0; end
    if (valid) begin
      if (pix_rgb !== 6'(col + HS)) pix_bad++;
      if (!seen) begin
        first_col = col; first_row = row; first_rgb = pix_rgb; seen = 1;
      end else if (!((col == last_col + 10'd1 && row == last_row) ||
                     (col == 0 && row == last_row + 10'd1))) seq_bad++;
      last_col = col; last_row = row; fr_valid++;
      if (!locked) seq_bad++;
    end else if (locked && (pix_rgb !== 0 || col !== 0 || row !== 0)) pix_bad++;
  end

  task automatic drive_px(input logic hs, input logic vs, input int p);
    @(negedge clk);
    HSYNC = hs; VSYNC = vs; rgb = 6'(p);
  endtask

  task automatic gen_line(input int len, input bit vs_low, input int first_p);
    for (int p = first_p; p < len; p++) drive_px(p >= HSW, !vs_low, p);
  endtask

  task automatic gen_frame(input int lines, input int short_idx, input int short_len);
    for (int l = 0; l < lines; l++) gen_line(l == short_idx ? short_len : HT, l == 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_px(1'b1, 1'b1, 0);
  endtask

  task automatic test_reset;
    reset = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; rgb = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({col, row, valid, pix_rgb, frame_start, locked, line_len, err_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: col=%0d row=%0d valid=%0b rgb=%0d fs=%0b locked=%0b len=%0d err=%0d, want all 0",
               col, row, valid, pix_rgb, frame_start, locked, line_len, err_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_acquire;
    idle(5);
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL acquire_first_frame locked=%0b want 0", locked); end
    drive_px(1'b0, 1'b0, 0);
    drive_px(1'b0, 1'b0, 1);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL acquire_early locked=%0b want 0", locked); end
    drive_px(1'b1, 1'b0, 2);
    checks++; if (locked !== 1'b1) begin failures++; $display("FAIL acquire_rise locked=%0b want 1", locked); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL acquire_frame_start got=%0b want 1", frame_start); end
    gen_line(HT, 1'b1, 3);
    for (int l = 1; l < VT; l++) gen_line(HT, 1'b0, 0);
    checks++; if (line_len !== 11'd10) begin failures++; $display("FAIL acquire_line_len got=%0d want 10", line_len); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL acquire_err got=%0d want 0", err_count); end
  endtask

  task automatic test_pixel_mapping;
    int pb, sb;
    pb = pix_bad; sb = seq_bad;
    gen_frame(VT, -1, 0);
    checks++; if (fr_valid != HV * VV) begin failures++; $display("FAIL pix_valid_count got=%0d want %0d", fr_valid, HV * VV); end
    checks++; if ({first_col, first_row} !== 20'd0) begin failures++; $display("FAIL pix_first got col=%0d row=%0d want 0/0", first_col, first_row); end
    checks++; if (first_rgb !== 6'd3) begin failures++; $display("FAIL pix_first_rgb got=%0d want 3", first_rgb); end
    checks++; if (last_col !== 10'd4 || last_row !== 10'd2) begin failures++; $display("FAIL pix_last got col=%0d row=%0d want 4/2", last_col, last_row); end
    checks++; if (pix_bad != pb) begin failures++; $display("FAIL pix_data bad=%0d want 0", pix_bad - pb); end
    checks++; if (seq_bad != sb) begin failures++; $display("FAIL pix_sequence bad=%0d want 0", seq_bad - sb); end
  endtask

  task automatic test_short_line;
    gen_line(HT, 1'b1, 0);
    gen_line(HT, 1'b0, 0);
    gen_line(HT, 1'b0, 0);
    gen_line(HT - 1, 1'b0, 0);
    gen_line(3, 1'b0, 0);
    checks++; if (line_len !== 11'd9) begin failures++; $display("FAIL short_line_len got=%0d want 9", line_len); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL short_err got=%0d want 1", err_count); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_locked got=%0b want 0", locked); end
    gen_line(HT, 1'b0, 3);
    gen_line(HT, 1'b0, 0);
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL short_check_frame locked=%0b want 0", locked); end
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL short_relock locked=%0b err=%0d want 1/1", locked, err_count); end
  endtask

  task automatic test_lost_hsync;
    idle(2000);
    checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin failures++; $display("FAIL lost_before_sat locked=%0b err=%0d want 1/1", locked, err_count); end
    idle(1000);
    checks++; if (locked !== 1'b0 || err_count !== 8'd2) begin failures++; $display("FAIL lost_after_sat locked=%0b err=%0d want 0/2", locked, err_count); end
    gen_frame(VT, -1, 0);
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b1 || err_count !== 8'd2) begin failures++; $display("FAIL lost_relock locked=%0b err=%0d want 1/2", locked, err_count); end
  endtask

  task automatic test_bad_frame;
    int fs0;
    gen_frame(VT - 1, -1, 0);
    gen_line(3, 1'b1, 0);
    checks++; if (err_count !== 8'd3 || locked !== 1'b0) begin failures++; $display("FAIL badframe err=%0d locked=%0b want 3/0", err_count, locked); end
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL badframe_fs got=%0b want 1", frame_start); end
    gen_line(HT, 1'b1, 3);
    for (int l = 1; l < VT; l++) gen_line(HT, 1'b0, 0);
    fs0 = fs_cnt;
    gen_frame(VT, -1, 0);
    checks++; if (fs_cnt - fs0 != 1) begin failures++; $display("FAIL coincident_fs_pulses got=%0d want 1", fs_cnt - fs0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL coincident_check locked=%0b want 0", locked); end
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b1 || err_count !== 8'd3) begin failures++; $display("FAIL coincident_relock locked=%0b err=%0d want 1/3", locked, err_count); end
  endtask

  task automatic test_reset_mid_line;
    gen_line(HT, 1'b1, 0);
    gen_line(HT, 1'b0, 0);
    gen_line(7, 1'b0, 0);
    checks++; if (valid !== 1'b1 || pix_rgb !== 6'd3) begin failures++; $display("FAIL midline_pre valid=%0b rgb=%0d want 1/3", valid, pix_rgb); end
    #2 reset = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1;
    #1;
    checks++;
    if ({col, row, valid, pix_rgb, frame_start, locked, line_len, err_count} !== '0) begin
      failures++;
      $display("FAIL midline_reset col=%0d row=%0d valid=%0b rgb=%0d fs=%0b locked=%0b len=%0d err=%0d, want all 0",
               col, row, valid, pix_rgb, frame_start, locked, line_len, err_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(3);
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b0) begin failures++; $display("FAIL midline_check locked=%0b want 0", locked); end
    gen_frame(VT, -1, 0);
    checks++; if (locked !== 1'b1 || err_count !== 8'd0) begin failures++; $display("FAIL midline_relock locked=%0b err=%0d want 1/0", locked, err_count); end
  endtask

  task automatic test_err_saturation;
    for (int i = 0; i < 300; i++) begin
      gen_frame(VT, 3, HT - 1);
      gen_frame(VT, -1, 0);
      if (i == 9) begin
        checks++; if (err_count !== 8'd10) begin failures++; $display("FAIL sat_count10 got=%0d want 10", err_count); end
      end
      if (i == 254) begin
        checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d want 255", err_count); end
      end
    end
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d want 255", err_count); end
  endtask

  initial begin
    test_reset;
    test_acquire;
    test_pixel_mapping;
    test_short_line;
    test_lost_hsync;
    test_bad_frame;
    test_reset_mid_line;
    test_err_saturation;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
